time_set_ctrl: RTL
==================

# time_set_ctrl

Timekeeping and time-set controller for the six-digit HH:MM:SS display. It holds the BCD time registers and advances them once per second. A two-button state machine lets the user set hours, minutes and seconds. It drives the six BCD digit buses consumed by the display scanner, forcing the field being edited to blank (4'hF) on alternate half-seconds so that field blinks.

## Interface
- TICK_DIV, 100_000_000 — clk cycles per second; even, ≥ 4.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- btn_mode  in  1  mode button, synchronous and debounced level; a rising edge is one press.
- btn_inc  in  1  increment button, synchronous and debounced level; a rising edge is one press.
- sec0, sec1, min0, min1, hour0, hour1  out  4 each  BCD digits to the scanner; 4'hF means blank.
- running  out  1  1 in RUN state.
- sec_tick  out  1  one-cycle pulse when the time advances in RUN.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC.
- Mode press transitions: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- Press detection: registered copy of each button. Press = btn=1 and btn_q=0 at a clk edge.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - At count TICK_DIV-1 the prescaler wraps, the time advances by one second, and sec_tick=1 for that cycle.
  - Carries: sec 59→00 with min+1; min 59→00 with hour+1; 23:59:59→00:00:00.
  - Inc presses are ignored.
- SET_x:
  - Time and prescaler are frozen; the prescaler is held at 0.
  - Inc press increments only the selected field, with no carry: hour 23→00, min 59→00, sec 59→00.
- Leaving SET_SEC: prescaler is 0, so the first RUN second is a full TICK_DIV cycles.
- Digits are always valid BCD internally: units 0–9, tens 0–5 (hour tens 0–2).
- Blink:
  - A phase bit toggles every TICK_DIV/2 cycles, from its own counter, in SET states only.
  - Phase is forced to 1 (visible) on entry to any SET state and in RUN.
  - With phase=0, both digits of the selected field output 4'hF.
  - Other fields and the internal registers are unaffected.
- Simultaneous events:
  - Mode and inc pressed in the same cycle: mode wins, inc is discarded.
  - Inc press and prescaler wrap in the same cycle cannot conflict, because the states are disjoint.

## Timing
- All outputs are registered except the blanking mux. The mux is combinational from the phase register and the state register; no input-to-output combinational path exists.
- Reset values: digits all 0 (00:00:00 displayed), state RUN, running=1, sec_tick=0, prescaler 0, blink counter 0, phase 1, btn_q=0.
- Press latency: a button rising at edge N is captured in btn_q at N. The action takes effect at edge N+1 and is visible on outputs after N+1.
- A held button produces exactly one action. A new press needs a low cycle in between.
- Seconds advance visibly TICK_DIV cycles after reset, and every TICK_DIV cycles thereafter while in RUN.
- Reset asserted mid-set or mid-count returns immediately to the reset values. The first edge after deassertion starts counting from 0.

## Configuration
- TIMER_BLINK_EN defined: blink phase logic and blanking as above.
- TIMER_BLINK_EN undefined:
  - No blink counter; selected digits always show their value.
  - State is visible only via running=0.
  - All other behaviour is identical.

## Test plan
- Reset/run, TICK_DIV=4:
  - Release rst; after 4 cycles → sec0=1, sec_tick pulses once.
  - After 40 cycles → sec1=1, sec0=0.
- Rollover: preload 23:59:59 via set mode, return to RUN, wait 4 cycles → 00:00:00, with a single sec_tick.
- Set hours:
  - 1 mode press → running=0.
  - 25 inc presses from 00 → hour1=0, hour0=1 (wrap 23→00 then +1). Minutes and seconds unchanged.
- Blink (TIMER_BLINK_EN, TICK_DIV=4): in SET_MIN → min0/min1 alternate between value and 4'hF every 2 cycles; hour and sec digits are steady.
- Simultaneous press: mode and inc both rise in the same cycle while in SET_HOUR → state becomes SET_MIN, hour unchanged.
- Reset mid-set: assert rst during SET_SEC with 12:34:56 → outputs 00:00:00, running=1 while rst is high.

Source files
------------

// File: rtl/time_set_ctrl.sv
// HH:MM:SS timekeeper with a two-button set FSM and BCD digit outputs.
// Optional macro TIMER_BLINK_EN enables blinking of the field being edited.

// One two-digit BCD field that wraps from MAX back to 00.
module time_bcd_field #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       at_max
);
  localparam logic [3:0] T_MAX = 4'(MAX / 10);
  localparam logic [3:0] U_MAX = 4'(MAX % 10);

  assign at_max = (tens == T_MAX) && (units == U_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        units <= '0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end
endmodule

module time_set_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hour0,
  output logic [3:0] hour1,
  output logic       running,
  output logic       sec_tick
);
  localparam int NUM_FLD = 3;  // 0 = sec, 1 = min, 2 = hour
  localparam int PW      = $clog2(TICK_DIV);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t                      state, state_n;
  logic [PW-1:0]               presc;
  logic                        wrap;
  logic                        mode_q, inc_q, mode_p, inc_p, inc_act;
  logic [NUM_FLD-1:0]          fld_inc, at_max, blank;
  logic [NUM_FLD-1:0][3:0]     tens, units;

  // Presses are registered, so an action lands one edge after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      mode_p <= 1'b0;
      inc_p  <= 1'b0;
    end else begin
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      mode_p <= btn_mode & ~mode_q;
      inc_p  <= btn_inc & ~inc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (mode_p) begin
      case (state)
        RUN:      state_n = SET_HOUR;
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        default:  state_n = RUN;
      endcase
    end
  end

  assign wrap    = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign inc_act = inc_p & ~mode_p;

  // Run-mode carries and set-mode increments never coincide (disjoint states).
  assign fld_inc[0] = wrap | (inc_act && state == SET_SEC);
  assign fld_inc[1] = (wrap & at_max[0]) | (inc_act && state == SET_MIN);
  assign fld_inc[2] = (wrap & at_max[0] & at_max[1]) | (inc_act && state == SET_HOUR);

  for (genvar f = 0; f < NUM_FLD; f++) begin : g_fld
    time_bcd_field #(.MAX(f == 2 ? 23 : 59)) u_fld (
      .clk    (clk),
      .rst    (rst),
      .inc    (fld_inc[f]),
      .tens   (tens[f]),
      .units  (units[f]),
      .at_max (at_max[f])
    );
  end

  // Prescaler only counts while staying in RUN, so the first second after
  // leaving set mode is a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      running  <= 1'b1;
    end else begin
      sec_tick <= wrap;
      running  <= (state_n == RUN);
      if (state != RUN || state_n != RUN || wrap) presc <= '0;
      else                                        presc <= presc + PW'(1);
    end
  end

`ifdef TIMER_BLINK_EN
  localparam int HALF = TICK_DIV / 2;
  localparam int BW   = $clog2(HALF);

  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (state_n == RUN || state_n != state) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(HALF - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  always_comb begin
    blank = '0;
    if (!phase) begin
      case (state)
        SET_HOUR: blank[2] = 1'b1;
        SET_MIN:  blank[1] = 1'b1;
        SET_SEC:  blank[0] = 1'b1;
        default:  blank    = '0;
      endcase
    end
  end
`else
  assign blank = '0;
`endif

  assign sec0  = blank[0] ? 4'hF : units[0];
  assign sec1  = blank[0] ? 4'hF : tens[0];
  assign min0  = blank[1] ? 4'hF : units[1];
  assign min1  = blank[1] ? 4'hF : tens[1];
  assign hour0 = blank[2] ? 4'hF : units[2];
  assign hour1 = blank[2] ? 4'hF : tens[2];
endmodule
